// File: rtl/fns_dec_rr_sched_if.sv
// Request/response bundle for the shared FNS decoder scheduler.
// slave = scheduler side, master = lane/consumer side.
interface fns_dec_rr_sched_if #(
  parameter int NLANE = 4,
  parameter int LW    = 2,
  parameter int CW    = 33,
  parameter int DW    = 24
);
  logic [NLANE-1:0]    req_valid;
  logic [NLANE*CW-1:0] req_code;
  logic [NLANE-1:0]    req_ready;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [LW-1:0]       out_lane;
  logic                out_ready;

  modport master (
    output req_valid, req_code, out_ready,
    input  req_ready, out_valid, out_data, out_lane
  );

  modport slave (
    input  req_valid, req_code, out_ready,
    output req_ready, out_valid, out_data, out_lane
  );
endinterface

// File: rtl/fns_dec_rr_sched.sv
// Round-robin scheduler sharing one combinational FNS decoder among NLANE lanes,
// with a code stage (A) feeding the decoder and a registered output stage (B).
module fns_dec_rr_sched #(
  parameter int NLANE = 4,
  parameter int LW    = 2,
  parameter int CW    = 33,
  parameter int DW    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  fns_dec_rr_sched_if.slave    bus,
  output logic [CW-1:0]        dec_codein,
  input  logic [DW-1:0]        dec_dataout,
  output logic                 busy,
  output logic [15:0]          dec_cnt
);

  localparam logic [LW:0]   NL   = (LW+1)'(NLANE);
  localparam logic [LW-1:0] LAST = LW'(NLANE-1);

  logic          vld_a;
  logic [CW-1:0] code_a;
  logic [LW-1:0] lane_a;
  logic [LW-1:0] ptr;
  logic          ov;
  logic [DW-1:0] od;
  logic [LW-1:0] ol;

  logic          adv_a, adv_b, acc, found;
  logic [LW-1:0] g;
  logic [LW:0]   idx;
  logic [CW-1:0] code_g;

  assign adv_b = !ov || bus.out_ready;
  assign adv_a = !vld_a || adv_b;
  assign acc   = adv_a && !rst && (|bus.req_valid);

  // First requesting lane at or after ptr, wrapping modulo NLANE.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NLANE; k++) begin
      idx = {1'b0, ptr} + (LW+1)'(k);
      if (idx >= NL) idx = idx - NL;
      if (!found && bus.req_valid[idx[LW-1:0]]) begin
        found = 1'b1;
        g     = idx[LW-1:0];
      end
    end
  end

  assign code_g        = bus.req_code[g*CW +: CW];
  assign bus.req_ready = acc ? (NLANE'(1) << g) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_a   <= 1'b0;
      code_a  <= '0;
      lane_a  <= '0;
      ptr     <= '0;
      ov      <= 1'b0;
      od      <= '0;
      ol      <= '0;
      dec_cnt <= '0;
    end else begin
      if (adv_b) begin
        ov <= vld_a;
        if (vld_a) begin
          od <= dec_dataout;
          ol <= lane_a;
        end
      end
      if (adv_a) begin
        vld_a <= acc;
        if (acc) begin
          code_a <= code_g;
          lane_a <= g;
          ptr    <= (g == LAST) ? '0 : g + 1'b1;
        end
      end
      if (ov && bus.out_ready) dec_cnt <= dec_cnt + 16'd1;
    end
  end

  assign dec_codein    = code_a;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_lane  = ol;
  assign busy          = vld_a | ov;

endmodule

// File: tb/tb_fns_dec_rr_sched.sv
// Directed and randomized checks of the round-robin FNS decoder scheduler,
// with an FNS weighted-sum decoder model driving dec_dataout.
module tb_fns_dec_rr_sched;
  localparam int NLANE = 4;
  localparam int LW    = 2;
  localparam int CW    = 33;
  localparam int DW    = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] dec_codein;
  logic [DW-1:0] dec_dataout;
  logic          busy;
  logic [15:0]   dec_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [LW-1:0] lane;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  ent_t          e;
  logic [3:0]    lv;
  logic [32:0]   lc [4];
  logic          ordy;
  int unsigned   mptr, gm, deliv;
  logic          accm, anym;
  int            n;
  logic [15:0]   cnt;
  logic [23:0]   fair_d [4];

  fns_dec_rr_sched_if #(.NLANE(NLANE), .LW(LW), .CW(CW), .DW(DW)) bus ();

  fns_dec_rr_sched #(.NLANE(NLANE), .LW(LW), .CW(CW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dec_codein  (dec_codein),
    .dec_dataout (dec_dataout),
    .busy        (busy),
    .dec_cnt     (dec_cnt)
  );

  always #5 clk = ~clk;

  // Fibonacci weights 1,2,3,5,8,... on codeword bits 0,1,2,...
  function automatic logic [23:0] fns(input logic [32:0] c);
    logic [23:0] a, b, t, s;
    a = 24'd1;
    b = 24'd2;
    s = '0;
    for (int i = 0; i < 33; i++) begin
      if (c[i]) s = s + a;
      t = a + b;
      a = b;
      b = t;
    end
    return s;
  endfunction

  always_comb dec_dataout = fns(dec_codein);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_code(input int unsigned i, input logic [32:0] c);
    bus.req_code[i*CW +: CW] = c;
  endtask

  initial begin
    fair_d[0] = 24'd2; fair_d[1] = 24'd3; fair_d[2] = 24'd5; fair_d[3] = 24'd8;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_code  = '0;
    bus.out_ready = 1'b1;

    // reset with every lane requesting
    tick; settle;
    chk("rst_ready",   64'(bus.req_ready), 64'(0));
    chk("rst_ovalid",  64'(bus.out_valid), 64'(0));
    chk("rst_cnt",     64'(dec_cnt),       64'(0));
    chk("rst_busy",    64'(busy),          64'(0));
    chk("rst_codein",  64'(dec_codein),    64'(0));
    tick; settle;
    chk("rst_ready2",  64'(bus.req_ready), 64'(0));

    // single word on lane 2
    rst = 1'b0;
    bus.req_valid = 4'b0100;
    set_code(2, 33'h1);
    settle;
    chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick;
    bus.req_valid = '0;
    settle;
    chk("single_lat",    64'(bus.out_valid), 64'(0));
    chk("single_busy",   64'(busy),          64'(1));
    chk("single_codein", 64'(dec_codein),    64'(1));
    tick; settle;
    chk("single_ov",   64'(bus.out_valid), 64'(1));
    chk("single_data", 64'(bus.out_data),  64'(1));
    chk("single_lane", 64'(bus.out_lane),  64'(2));
    bus.req_valid = 4'b0100;
    set_code(2, 33'h0);
    settle;
    chk("zero_ready", 64'(bus.req_ready), 64'(4'b0100));
    tick;
    bus.req_valid = '0;
    settle;
    chk("zero_cnt1", 64'(dec_cnt), 64'(1));
    tick; settle;
    chk("zero_ov",   64'(bus.out_valid), 64'(1));
    chk("zero_data", 64'(bus.out_data),  64'(0));
    chk("zero_lane", 64'(bus.out_lane),  64'(2));
    tick; settle;
    chk("zero_cnt2", 64'(dec_cnt), 64'(2));
    chk("zero_busy", 64'(busy),    64'(0));

    // fairness: all lanes requesting, ptr cleared by reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_code(0, 33'h02); set_code(1, 33'h04); set_code(2, 33'h08); set_code(3, 33'h10);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      settle;
      if (k < 8) chk("fair_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        chk("fair_ov",   64'(bus.out_valid), 64'(1));
        chk("fair_lane", 64'(bus.out_lane),  64'((k - 2) % 4));
        chk("fair_data", 64'(bus.out_data),  64'(fair_d[(k - 2) % 4]));
      end
      tick;
      if (k == 7) bus.req_valid = '0;
    end
    settle;
    chk("fair_drain", 64'(bus.out_valid), 64'(0));
    chk("fair_cnt",   64'(dec_cnt),       64'(8));
    chk("fair_busy",  64'(busy),          64'(0));

    // backpressure: two buffered words then full stall
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0011;
    settle;
    chk("bp_ready0", 64'(bus.req_ready), 64'(4'b0001));
    tick; settle;
    chk("bp_ready1", 64'(bus.req_ready), 64'(4'b0010));
    tick;
    for (int c = 2; c < 5; c++) begin
      settle;
      chk("bp_stall", 64'(bus.req_ready), 64'(0));
      chk("bp_ov",    64'(bus.out_valid), 64'(1));
      chk("bp_data",  64'(bus.out_data),  64'(2));
      chk("bp_lane",  64'(bus.out_lane),  64'(0));
      tick;
    end
    bus.out_ready = 1'b1;
    settle;
    chk("bp_rel_ready", 64'(bus.req_ready), 64'(4'b0001));
    chk("bp_rel_lane",  64'(bus.out_lane),  64'(0));
    tick;
    bus.req_valid = '0;
    settle;
    chk("bp_w1_lane", 64'(bus.out_lane), 64'(1));
    chk("bp_w1_data", 64'(bus.out_data), 64'(3));
    tick; settle;
    chk("bp_w2_ov",   64'(bus.out_valid), 64'(1));
    chk("bp_w2_lane", 64'(bus.out_lane),  64'(0));
    chk("bp_w2_data", 64'(bus.out_data),  64'(2));
    tick; settle;
    chk("bp_drain", 64'(bus.out_valid), 64'(0));
    chk("bp_cnt",   64'(dec_cnt),       64'(11));

    // reset with both stages full
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0011;
    tick; tick; settle;
    chk("mid_busy", 64'(busy),          64'(1));
    chk("mid_ov",   64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'hF;
    settle;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    tick;
    rst = 1'b0;
    settle;
    chk("mid_ov0",   64'(bus.out_valid), 64'(0));
    chk("mid_busy0", 64'(busy),          64'(0));
    chk("mid_cnt0",  64'(dec_cnt),       64'(0));
    chk("mid_ptr0",  64'(bus.req_ready), 64'(4'b0001));
    tick;
    bus.req_valid = '0;
    tick; settle;
    chk("mid_lane", 64'(bus.out_lane),  64'(0));
    chk("mid_data", 64'(bus.out_data),  64'(2));
    tick;

    // random traffic against a reference arbiter and in-order scoreboard
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mptr = 0; n = 0; cnt = '0; q.delete();
    for (int i = 0; i < 4; i++) begin
      lv[i] = 1'($urandom_range(0, 1));
      lc[i] = 33'({$urandom_range(0, 1), $urandom()});
    end
    ordy = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.req_valid = lv;
      for (int i = 0; i < 4; i++) set_code(i, lc[i]);
      bus.out_ready = ordy;
      settle;
      anym = |lv;
      gm = 0;
      for (int k = 3; k >= 0; k--) if (lv[(mptr + k) % 4]) gm = (mptr + k) % 4;
      accm = anym && !(n == 2 && !ordy);
      chk("rnd_ready", 64'(bus.req_ready), accm ? 64'(4'b0001 << gm) : 64'(0));
      if (n == 2) chk("rnd_full_ov", 64'(bus.out_valid), 64'(1));
      if (bus.out_valid) begin
        chk("rnd_nonempty", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          chk("rnd_lane", 64'(bus.out_lane), 64'(q[0].lane));
          chk("rnd_data", 64'(bus.out_data), 64'(q[0].data));
          if (ordy) begin
            void'(q.pop_front());
            n--;
            cnt++;
          end
        end
      end
      if (accm) begin
        e.lane = LW'(gm);
        e.data = fns(lc[gm]);
        q.push_back(e);
        n++;
        mptr = (gm == 3) ? 0 : gm + 1;
      end
      tick;
      if (accm) begin
        lv[gm] = 1'($urandom_range(0, 1));
        lc[gm] = 33'({$urandom_range(0, 1), $urandom()});
      end
      for (int i = 0; i < 4; i++) begin
        if (!lv[i]) begin
          lv[i] = ($urandom_range(0, 2) == 0);
          lc[i] = 33'({$urandom_range(0, 1), $urandom()});
        end
      end
      ordy = ($urandom_range(0, 9) < 7);
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle;
      if (bus.out_valid && q.size() > 0) begin
        chk("drain_lane", 64'(bus.out_lane), 64'(q[0].lane));
        chk("drain_data", 64'(bus.out_data), 64'(q[0].data));
        void'(q.pop_front());
        cnt++;
      end
      tick;
    end
    settle;
    chk("rnd_qempty", 64'(q.size()), 64'(0));
    chk("rnd_busy",   64'(busy),     64'(0));
    chk("rnd_cnt",    64'(dec_cnt),  64'(cnt));

    // delivery counter wrap
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    deliv = 0;
    for (int i = 0; i < 70000 && deliv < 65536; i++) begin
      settle;
      if (bus.out_valid) deliv++;
      tick;
      if (deliv == 65535) chk("wrap_ffff", 64'(dec_cnt), 64'(16'hFFFF));
      if (deliv == 65536) chk("wrap_zero", 64'(dec_cnt), 64'(0));
    end
    chk("wrap_count", 64'(deliv), 64'(65536));
    bus.req_valid = '0;
    tick; tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
